// File: rtl/lcd_char_scheduler.sv
// lcd_char_scheduler
//   Shares the LCD character-write port between two byte requesters.
//   Requests are arbitrated round-robin into a small FIFO. Nothing is written
//   until the LCD power-on init time has passed. Each write is a one-cycle
//   strobe followed by a fixed gap, because the LCD gives no completion flag.
//
// Ports
//   Clock, Reset        system clock; synchronous active-high reset
//   iReq0Valid/Data     requester 0 (ALU result byte)
//   oReq0Ready          requester 0 byte accepted when Valid && Ready
//   iReq1Valid/Data     requester 1 (debug/status byte)
//   oReq1Ready          requester 1 accept qualifier
//   oLcdStrobe          one-cycle pulse per character (LCD externalInput)
//   oLcdData            character byte (LCD alu_data), held until next pop
//   oBusy               high while initialising, strobing or in the gap
//   oFifoCount          current FIFO occupancy
//   oCharCount          characters issued since reset, wraps at 256
//   oDbgState           current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where Valid && Ready are both
// high. Ready is combinational. It never depends on the requester's own Valid,
// and at most one requester is ready whenever both are valid.

module lcd_char_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int INIT_WAIT  = 1100000,
    parameter int WRITE_GAP  = 4000,
    parameter int CNT_W      = 32
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          iReq0Valid,
    input  logic [7:0]                    iReq0Data,
    output logic                          oReq0Ready,
    input  logic                          iReq1Valid,
    input  logic [7:0]                    iReq1Data,
    output logic                          oReq1Ready,
    output logic                          oLcdStrobe,
    output logic [7:0]                    oLcdData,
    output logic                          oBusy,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoCount,
    output logic [7:0]                    oCharCount,
    output logic [1:0]                    oDbgState
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT  = FIFO_DEPTH[PTR_W:0];
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(WRITE_GAP - 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_STROBE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       char_q, char_d;
    logic             rr_q, rr_d;      // 0: req0 owns the tie, 1: req1
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic       full;
    logic       push0, push1, push, pop;
    logic [7:0] push_data;

    // Arbitration. Fullness uses the current occupancy only, so a pop in the
    // same cycle never opens room for a push.
    always_comb begin
        full       = (count_q == FULL_CNT);
        oReq0Ready = !Reset && !full && (!iReq1Valid || !rr_q);
        oReq1Ready = !Reset && !full && (!iReq0Valid ||  rr_q);
        push0      = iReq0Valid && oReq0Ready;
        push1      = iReq1Valid && oReq1Ready;
        push       = push0 || push1;
        push_data  = push0 ? iReq0Data : iReq1Data;
        // Hand the tie to whoever was not served.
        rr_d       = push ? push0 : rr_q;
    end

    // Sequencer: init wait, then strobe and gap for each queued byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        char_d  = char_q;
        pop     = 1'b0;
        case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_STROBE;
                    data_d  = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                end
            end
            S_STROBE: begin
                state_d = S_GAP;
                char_d  = char_q + 1'b1;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            char_q   <= '0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            char_q   <= char_d;
            rr_q     <= rr_d;
        end
    end

    // Storage needs no reset; the pointers and the count define validity.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign oLcdStrobe = (state_q == S_STROBE);
    assign oLcdData   = data_q;
    assign oBusy      = (state_q != S_IDLE);
    assign oFifoCount = count_q;
    assign oCharCount = char_q;
    assign oDbgState  = state_q;

endmodule

// File: tb/tb_lcd_char_scheduler.sv
// Testbench for lcd_char_scheduler (short init/gap timing).
module tb_lcd_char_scheduler;

    localparam int IW    = 20;
    localparam int WG    = 5;
    localparam int DEPTH = 8;

    logic       Clock;
    logic       Reset;
    logic       iReq0Valid, iReq1Valid;
    logic [7:0] iReq0Data, iReq1Data;
    logic       oReq0Ready, oReq1Ready;
    logic       oLcdStrobe, oBusy;
    logic [7:0] oLcdData, oCharCount;
    logic [3:0] oFifoCount;
    logic [1:0] oDbgState;

    lcd_char_scheduler #(
        .FIFO_DEPTH(DEPTH), .INIT_WAIT(IW), .WRITE_GAP(WG), .CNT_W(32)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iReq0Valid(iReq0Valid), .iReq0Data(iReq0Data), .oReq0Ready(oReq0Ready),
        .iReq1Valid(iReq1Valid), .iReq1Data(iReq1Data), .oReq1Ready(oReq1Ready),
        .oLcdStrobe(oLcdStrobe), .oLcdData(oLcdData), .oBusy(oBusy),
        .oFifoCount(oFifoCount), .oCharCount(oCharCount), .oDbgState(oDbgState)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    // The model describes the cycle it is compared in. A character can be
    // taken from the queue in any cycle at or after m_ready_at; its strobe
    // appears one cycle later and the next take is WG+2 cycles after it.
    typedef struct { int cyc; logic [7:0] data; } strobe_t;

    logic [7:0] exp_q[$];
    strobe_t    strobe_log[$];
    logic [8:0] acc_log[$];      // {source, byte}
    bit         m_live = 0;
    int         m_cyc = 0;
    int         m_ready_at = 0;
    logic       m_rr = 0;
    logic       m_strobe = 0;
    logic [7:0] m_data = 0;
    logic [7:0] m_char = 0;

    always @(negedge Clock) begin
        bit full, er0, er1, p0, p1, take;
        full = (exp_q.size() == DEPTH);
        er0  = !Reset && !full && (!iReq1Valid || m_rr == 1'b0);
        er1  = !Reset && !full && (!iReq0Valid || m_rr == 1'b1);
        if (m_live) begin
            chk("strobe",   oLcdStrobe, m_strobe);
            chk("lcd_data", oLcdData,   m_data);
            chk("fifo_cnt", oFifoCount, exp_q.size());
            chk("char_cnt", oCharCount, m_char);
            chk("busy",     oBusy,      m_cyc < m_ready_at);
            chk("ready0",   oReq0Ready, er0);
            chk("ready1",   oReq1Ready, er1);
        end
        if (Reset) begin
            m_live = 1;
            exp_q.delete();
            strobe_log.delete();
            acc_log.delete();
            m_cyc = 0;
            m_ready_at = IW;
            m_rr = 0;
            m_strobe = 0;
            m_data = 0;
            m_char = 0;
        end else if (m_live) begin
            p0   = iReq0Valid && er0;
            p1   = iReq1Valid && er1;
            take = (m_cyc >= m_ready_at) && (exp_q.size() > 0);
            if (m_strobe) m_char = m_char + 8'd1;
            if (take) begin
                m_data = exp_q.pop_front();
                m_strobe = 1;
                m_ready_at = m_cyc + WG + 2;
                strobe_log.push_back('{m_cyc + 1, m_data});
            end else begin
                m_strobe = 0;
            end
            if (p0) begin
                exp_q.push_back(iReq0Data);
                acc_log.push_back({1'b0, iReq0Data});
                m_rr = 1;
            end else if (p1) begin
                exp_q.push_back(iReq1Data);
                acc_log.push_back({1'b1, iReq1Data});
                m_rr = 0;
            end
            m_cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset (1 time unit after the edge).
    task automatic do_reset();
        Reset = 1;
        iReq0Valid = 0;
        iReq1Valid = 0;
        step(2);
        Reset = 0;
    endtask

    task automatic push_req(input bit src, input logic [7:0] d);
        bit done;
        done = 0;
        if (src == 0) begin iReq0Valid = 1; iReq0Data = d; end
        else          begin iReq1Valid = 1; iReq1Data = d; end
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            done = src ? oReq1Ready : oReq0Ready;
            step(1);
        end
        iReq0Valid = 0;
        iReq1Valid = 0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && m_cyc >= m_ready_at) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 0, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] d0, d1;
        logic r0, r1;
        Reset = 1;
        iReq0Valid = 0; iReq1Valid = 0;
        iReq0Data = 0;  iReq1Data = 0;

        // 1: byte queued during init waits for the init time
        do_reset();
        #1;
        chk("rst_strobe", oLcdStrobe, 0);
        chk("rst_count",  oFifoCount, 0);
        chk("rst_char",   oCharCount, 0);
        step(3);
        iReq0Valid = 1; iReq0Data = 8'h41;
        step(1);
        iReq0Valid = 0;
        wait_idle(100);
        chk("t1_nstrobe", strobe_log.size(), 1);
        if (strobe_log.size() == 1) begin
            chk("t1_cycle", strobe_log[0].cyc, 21);
            chk("t1_data",  strobe_log[0].data, 8'h41);
        end
        chk("t1_char", oCharCount, 1);

        // 2: both requesters always valid -> alternating service, 7-cycle spacing
        do_reset();
        step(22);
        d0 = 8'h30; d1 = 8'h61;
        for (int k = 0; k < 40; k++) begin
            iReq0Valid = 1; iReq0Data = d0;
            iReq1Valid = 1; iReq1Data = d1;
            #1;
            r0 = oReq0Ready; r1 = oReq1Ready;
            step(1);
            if (r0) d0 = d0 + 8'd1;
            if (r1) d1 = d1 + 8'd1;
        end
        iReq0Valid = 0; iReq1Valid = 0;
        wait_idle(300);
        chk("t2_acc0", acc_log[0], 9'h030);
        chk("t2_acc1", acc_log[1], 9'h161);
        chk("t2_acc2", acc_log[2], 9'h031);
        chk("t2_acc3", acc_log[3], 9'h162);
        for (int i = 0; i < acc_log.size(); i++)
            chk("t2_alt", acc_log[i][8], i % 2);
        chk("t2_nstrobe", strobe_log.size(), acc_log.size());
        for (int i = 1; i < strobe_log.size(); i++)
            chk("t2_spacing", strobe_log[i].cyc - strobe_log[i-1].cyc, 7);

        // 3: fill the FIFO during init, then check full behaviour and order
        do_reset();
        for (int k = 0; k < 8; k++) begin
            iReq1Valid = 1; iReq1Data = 8'h80 + k[7:0];
            step(1);
        end
        iReq0Valid = 1; iReq0Data = 8'h99;
        iReq1Data = 8'h88;
        #1;
        chk("t3_full_cnt", oFifoCount, 8);
        chk("t3_full_r0",  oReq0Ready, 0);
        chk("t3_full_r1",  oReq1Ready, 0);
        step(2);
        iReq0Valid = 0; iReq1Valid = 0;
        wait_idle(200);
        chk("t3_nstrobe", strobe_log.size(), 8);
        for (int k = 0; k < 8 && k < strobe_log.size(); k++)
            chk("t3_order", strobe_log[k].data, 8'h80 + k[7:0]);

        // 4: push in the cycle the head is popped, count stays 3
        do_reset();
        for (int k = 0; k < 3; k++) begin
            iReq0Valid = 1; iReq0Data = 8'h10 + k[7:0];
            step(1);
        end
        iReq0Valid = 0;
        step(17);                    // cycle 20: first pop
        iReq1Valid = 1; iReq1Data = 8'h13;
        #1;
        chk("t4_cnt_pre", oFifoCount, 3);
        step(1);
        iReq1Valid = 0;
        #1;
        chk("t4_cnt_post", oFifoCount, 3);
        chk("t4_strobe",   oLcdStrobe, 1);
        chk("t4_data",     oLcdData, 8'h10);
        wait_idle(100);
        chk("t4_nstrobe", strobe_log.size(), 4);
        for (int k = 0; k < 4 && k < strobe_log.size(); k++)
            chk("t4_order", strobe_log[k].data, 8'h10 + k[7:0]);

        // 5: reset in the gap discards the queue and restarts init
        do_reset();
        for (int k = 0; k < 5; k++) begin
            iReq0Valid = 1; iReq0Data = 8'h50 + k[7:0];
            step(1);
        end
        iReq0Valid = 0;
        step(18);                    // cycle 23: inside the gap
        chk("t5_cnt_gap",  oFifoCount, 4);
        chk("t5_busy_gap", oBusy, 1);
        Reset = 1;
        step(1);
        Reset = 0;
        #1;
        chk("t5_strobe", oLcdStrobe, 0);
        chk("t5_data",   oLcdData, 0);
        chk("t5_cnt",    oFifoCount, 0);
        chk("t5_state",  oDbgState, 0);
        chk("t5_busy",   oBusy, 1);
        iReq0Valid = 1; iReq0Data = 8'h5A;
        step(1);
        iReq0Valid = 0;
        wait_idle(100);
        chk("t5_nstrobe", strobe_log.size(), 1);
        if (strobe_log.size() == 1) begin
            chk("t5_cycle", strobe_log[0].cyc, 21);
            chk("t5_sdata", strobe_log[0].data, 8'h5A);
        end

        // 6: 257 characters -> character counter wraps to 1
        do_reset();
        for (int k = 0; k < 257; k++)
            push_req(k[0], k[7:0]);
        wait_idle(300);
        chk("t6_nstrobe", strobe_log.size(), 257);
        chk("t6_char",    oCharCount, 1);
        chk("t6_last",    oLcdData, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
